pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl_pkg.sv | 27 ++
 rtl/pipe_ctrl_cnt.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Contents: stage index constants for the 6-stage pipeline (PC, IF, ID, EX, MEM, WB),
//           the controller state encoding, and a helper that builds a
//           "stall from stage k" mask (bits [k:0] set).
package pipe_hazard_ctrl_pkg;

  // Default stall bus width and stage positions on that bus.
  localparam int unsigned STALL_W_DEF = 6;
  localparam int unsigned PC_STAGE    = 0;
  localparam int unsigned IF_STAGE    = 1;
  localparam int unsigned ID_STAGE    = 2;
  localparam int unsigned EX_STAGE    = 3;
  localparam int unsigned MEM_STAGE   = 4;
  localparam int unsigned WB_STAGE    = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MULTI = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Stall from stage k: freeze stage k and everything upstream of it.
  function automatic logic [63:0] stall_mask(input int unsigned k);
    stall_mask = (64'd1 << (k + 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/pipe_ctrl_cnt.sv
// Loadable down-counter shared by the multi-cycle length and the flush window.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   clear           - force counter to 0 (highest priority)
//   load, load_val  - load a new count
//   dec             - decrement by one; holds at 0, never wraps
//   zero_c, one_c   - combinational decodes of the current count
module pipe_ctrl_cnt #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_c,
  output logic         one_c
);

  logic [W-1:0] cnt;

  // Count register: clear > load > decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero_c = (cnt == '0);
  assign one_c  = (cnt == W'(1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: arbitrates ID load-use stalls, EX multi-cycle
// stalls and registered flushes with a redirect PC.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   stallreq_for_load  - load-use hazard in ID (level)
//   multi_start        - EX starts a multi-cycle op (pulse), multi_len sampled with it
//   flush_req          - flush request (pulse), flush_pc sampled with it
//   stall              - stall vector, combinational from state and current inputs
//   flush, new_pc      - registered pipeline kill and redirect target
//   busy               - registered, high while not IDLE
//   stall_cycles       - stall cycle counter (only with PIPE_CTRL_PERF_EN, else 0)
//   flush_count        - flush event counter (only with PIPE_CTRL_PERF_EN, else 0)
// Build option: define PIPE_CTRL_PERF_EN to synthesise the performance counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned STALL_W      = STALL_W_DEF,
  parameter int unsigned ID_IDX       = ID_STAGE,
  parameter int unsigned EX_IDX       = EX_STAGE,
  parameter int unsigned CNT_W        = 6,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned PC_W         = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_for_load,
  input  logic               multi_start,
  input  logic [CNT_W-1:0]   multi_len,
  input  logic               flush_req,
  input  logic [PC_W-1:0]    flush_pc,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [PC_W-1:0]    new_pc,
  output logic               busy,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        flush_count
);

  localparam logic [STALL_W-1:0] LOAD_MASK  = STALL_W'(stall_mask(ID_IDX));
  localparam logic [STALL_W-1:0] EX_MASK    = STALL_W'(stall_mask(EX_IDX));
  localparam logic [CNT_W-1:0]   FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  state_e             state;
  state_e             next_state;
  logic               flush_start;
  logic               cnt_clear;
  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_val;
  logic               cnt_dec;
  logic               cnt_zero;
  logic               cnt_one;

  pipe_ctrl_cnt #(
    .W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero_c   (cnt_zero),
    .one_c    (cnt_one)
  );

  // Arbitration: next state, stall vector and counter control.
  always_comb begin
    next_state  = state;
    stall       = '0;
    flush_start = 1'b0;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    cnt_dec     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (flush_req) begin
          next_state  = ST_FLUSH;
          flush_start = 1'b1;
        end else if (multi_start && (multi_len != '0)) begin
          // The start cycle is the first of multi_len stall cycles.
          stall    = EX_MASK;
          cnt_load = 1'b1;
          cnt_val  = multi_len - CNT_W'(1);
          if (multi_len > CNT_W'(1)) next_state = ST_MULTI;
        end else if (stallreq_for_load) begin
          stall = LOAD_MASK;
        end
      end
      ST_MULTI: begin
        if (flush_req) begin
          next_state  = ST_FLUSH;
          flush_start = 1'b1;
        end else begin
          stall   = EX_MASK;
          cnt_dec = 1'b1;
          if (cnt_one) next_state = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (flush_req) begin
          flush_start = 1'b1;
        end else if (cnt_zero) begin
          next_state = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
    // A new flush (re)starts the window; any pending multi count is dropped.
    if (flush_start) begin
      cnt_load = 1'b1;
      cnt_val  = FLUSH_LOAD;
    end
    // No stall leaks out while reset is being applied.
    if (rst) stall = '0;
  end

  // Keep the counter at 0 whenever the controller returns to IDLE.
  assign cnt_clear = (next_state == ST_IDLE) && (state != ST_IDLE);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      flush  <= 1'b0;
      new_pc <= '0;
      busy   <= 1'b0;
    end else begin
      state <= next_state;
      flush <= (next_state == ST_FLUSH);
      busy  <= (next_state != ST_IDLE);
      if (flush_start) new_pc <= flush_pc;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // Saturating performance counters; a flush event is a rise or a restart.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if ((stall != '0) && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (flush_start && (flush_count != 32'hFFFF_FFFF))
        flush_count <= flush_count + 32'd1;
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl. Two instances: dut_a at default
// parameters, dut_b with FLUSH_CYCLES=3. Stimulus pushes the expected
// per-cycle outputs; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [31:0] PERF_SC = 32'd4;
  localparam logic [31:0] PERF_FC = 32'd1;
`else
  localparam logic [31:0] PERF_SC = 32'd0;
  localparam logic [31:0] PERF_FC = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_a, ms_a, fr_a, ld_b, ms_b, fr_b;
  logic [5:0]  ml_a, ml_b;
  logic [31:0] fpc_a, fpc_b;
  logic [5:0]  stall_a, stall_b;
  logic        flush_a, flush_b, busy_a, busy_b;
  logic [31:0] npc_a, npc_b, sc_a, sc_b, fc_a, fc_b;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut_a (
    .clk(clk), .rst(rst), .stallreq_for_load(ld_a), .multi_start(ms_a),
    .multi_len(ml_a), .flush_req(fr_a), .flush_pc(fpc_a), .stall(stall_a),
    .flush(flush_a), .new_pc(npc_a), .busy(busy_a),
    .stall_cycles(sc_a), .flush_count(fc_a)
  );

  pipe_hazard_ctrl #(.FLUSH_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .stallreq_for_load(ld_b), .multi_start(ms_b),
    .multi_len(ml_b), .flush_req(fr_b), .flush_pc(fpc_b), .stall(stall_b),
    .flush(flush_b), .new_pc(npc_b), .busy(busy_b),
    .stall_cycles(sc_b), .flush_count(fc_b)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        busy;
    bit          perf;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Drive one cycle of inputs to the selected DUT and record what it must show.
  task automatic step(input string nm, input int sel, input logic r, l, m,
                      input logic [5:0] len, input logic f, input logic [31:0] pc,
                      input logic [5:0] es, input logic ef, input logic [31:0] ep,
                      input logic eb, input bit pf = 1'b0,
                      input logic [31:0] esc = 32'd0, input logic [31:0] efc = 32'd0);
    exp_t e;
    rst   = r;
    ld_a  = (sel == 0) && l;  ms_a = (sel == 0) && m;  fr_a = (sel == 0) && f;
    ld_b  = (sel == 1) && l;  ms_b = (sel == 1) && m;  fr_b = (sel == 1) && f;
    ml_a  = (sel == 0) ? len : 6'd0;
    ml_b  = (sel == 1) ? len : 6'd0;
    fpc_a = (sel == 0) ? pc : 32'd0;
    fpc_b = (sel == 1) ? pc : 32'd0;
    e.name = nm; e.sel = sel; e.stall = es; e.flush = ef; e.new_pc = ep;
    e.busy = eb; e.perf = pf; e.sc = esc; e.fc = efc;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the selected DUT's outputs mid-cycle against the queue head.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t        e;
      logic [5:0]  as;
      logic        af, ab;
      logic [31:0] ap, asc, afc;
      bit          bad;
      e = q.pop_front();
      if (e.sel == 0) begin
        as = stall_a; af = flush_a; ap = npc_a; ab = busy_a; asc = sc_a; afc = fc_a;
      end else begin
        as = stall_b; af = flush_b; ap = npc_b; ab = busy_b; asc = sc_b; afc = fc_b;
      end
      vectors++;
      bad = (as !== e.stall) || (af !== e.flush) || (ap !== e.new_pc) || (ab !== e.busy);
      if (e.perf) bad = bad || (asc !== e.sc) || (afc !== e.fc);
      if (bad) begin
        miscompares++;
        $display("FAIL %s: got stall=%h flush=%b new_pc=%h busy=%b sc=%0d fc=%0d; want stall=%h flush=%b new_pc=%h busy=%b sc=%0d fc=%0d",
                 e.name, as, af, ap, ab, asc, afc,
                 e.stall, e.flush, e.new_pc, e.busy, e.sc, e.fc);
      end
    end
  end

  initial begin
    rst = 1'b1;
    ld_a = 0; ms_a = 0; fr_a = 0; ml_a = 0; fpc_a = 0;
    ld_b = 0; ms_b = 0; fr_b = 0; ml_b = 0; fpc_b = 0;
    @(posedge clk); #1;
    //    name           sel rst ld ms len   fr pc            stall  fl new_pc        busy
    step("reset",         0, 1,  0, 0, 6'd0, 0, 32'h0,        6'h00, 0, 32'h0,        0, 1'b1, 32'd0, 32'd0);

    // Load-use in IDLE: one-cycle load mask.
    step("load_use",      0, 0,  1, 0, 6'd0, 0, 32'h0,        6'h07, 0, 32'h0,        0);
    step("load_release",  0, 0,  0, 0, 6'd0, 0, 32'h0,        6'h00, 0, 32'h0,        0);

    // multi_len=4: four EX-mask cycles, load request swallowed.
    step("multi4_c1",     0, 0,  0, 1, 6'd4, 0, 32'h0,        6'h0F, 0, 32'h0,        0);
    step("multi4_c2",     0, 0,  1, 0, 6'd0, 0, 32'h0,        6'h0F, 0, 32'h0,        1);
    step("multi4_c3",     0, 0,  1, 0, 6'd0, 0, 32'h0,        6'h0F, 0, 32'h0,        1);
    step("multi4_c4",     0, 0,  0, 0, 6'd0, 0, 32'h0,        6'h0F, 0, 32'h0,        1);
    step("multi4_done",   0, 0,  0, 0, 6'd0, 0, 32'h0,        6'h00, 0, 32'h0,        0);

    // Flush over a long multi-cycle op.
    step("fom_c1",        0, 0,  0, 1, 6'd10, 0, 32'h0,       6'h0F, 0, 32'h0,        0);
    step("fom_c2",        0, 0,  0, 0, 6'd0, 0, 32'h0,        6'h0F, 0, 32'h0,        1);
    step("fom_c3_req",    0, 0,  0, 0, 6'd0, 1, 32'h1234,     6'h00, 0, 32'h0,        1);
    step("fom_c4_flush",  0, 0,  0, 0, 6'd0, 0, 32'h0,        6'h00, 1, 32'h1234,     1);
    step("fom_c5",        0, 0,  0, 0, 6'd0, 0, 32'h0,        6'h00, 0, 32'h1234,     0);
    step("fom_no_resume", 0, 0,  0, 0, 6'd0, 0, 32'h0,        6'h00, 0, 32'h1234,     0);

    // flush_req + multi_start + load in one cycle: flush wins, no MULTI.
    step("simul_req",     0, 0,  1, 1, 6'd5, 1, 32'hABCD,     6'h00, 0, 32'h1234,     0);
    step("simul_flush",   0, 0,  0, 0, 6'd0, 0, 32'h0,        6'h00, 1, 32'hABCD,     1);
    step("simul_idle",    0, 0,  0, 0, 6'd0, 0, 32'h0,        6'h00, 0, 32'hABCD,     0);
    step("simul_load",    0, 0,  1, 0, 6'd0, 0, 32'h0,        6'h07, 0, 32'hABCD,     0);

    // Length boundaries: 0 is ignored, 1 stalls one cycle without MULTI.
    step("len0",          0, 0,  0, 1, 6'd0, 0, 32'h0,        6'h00, 0, 32'hABCD,     0);
    step("len0_after",    0, 0,  0, 0, 6'd0, 0, 32'h0,        6'h00, 0, 32'hABCD,     0);
    step("len1",          0, 0,  0, 1, 6'd1, 0, 32'h0,        6'h0F, 0, 32'hABCD,     0);
    step("len1_after",    0, 0,  0, 0, 6'd0, 0, 32'h0,        6'h00, 0, 32'hABCD,     0);

    // multi_start during MULTI is ignored.
    step("remulti_c1",    0, 0,  0, 1, 6'd3, 0, 32'h0,        6'h0F, 0, 32'hABCD,     0);
    step("remulti_c2",    0, 0,  0, 1, 6'd10, 0, 32'h0,       6'h0F, 0, 32'hABCD,     1);
    step("remulti_c3",    0, 0,  0, 0, 6'd0, 0, 32'h0,        6'h0F, 0, 32'hABCD,     1);
    step("remulti_done",  0, 0,  0, 0, 6'd0, 0, 32'h0,        6'h00, 0, 32'hABCD,     0);

    // Reset in the middle of MULTI.
    step("rstm_c1",       0, 0,  0, 1, 6'd8, 0, 32'h0,        6'h0F, 0, 32'hABCD,     0);
    step("rstm_c2",       0, 0,  0, 0, 6'd0, 0, 32'h0,        6'h0F, 0, 32'hABCD,     1);
    step("rstm_rst",      0, 1,  0, 0, 6'd0, 0, 32'h0,        6'h00, 0, 32'hABCD,     1);
    step("rstm_after",    0, 0,  0, 0, 6'd0, 0, 32'h0,        6'h00, 0, 32'h0,        0);

    // Performance scenario: multi_len=4 then one flush.
    step("perf_m1",       0, 0,  0, 1, 6'd4, 0, 32'h0,        6'h0F, 0, 32'h0,        0);
    step("perf_m2",       0, 0,  0, 0, 6'd0, 0, 32'h0,        6'h0F, 0, 32'h0,        1);
    step("perf_m3",       0, 0,  0, 0, 6'd0, 0, 32'h0,        6'h0F, 0, 32'h0,        1);
    step("perf_m4",       0, 0,  0, 0, 6'd0, 0, 32'h0,        6'h0F, 0, 32'h0,        1);
    step("perf_idle",     0, 0,  0, 0, 6'd0, 0, 32'h0,        6'h00, 0, 32'h0,        0);
    step("perf_freq",     0, 0,  0, 0, 6'd0, 1, 32'h55,       6'h00, 0, 32'h0,        0);
    step("perf_flush",    0, 0,  0, 0, 6'd0, 0, 32'h0,        6'h00, 1, 32'h55,       1);
    step("perf_counts",   0, 0,  0, 0, 6'd0, 0, 32'h0,        6'h00, 0, 32'h55,       0, 1'b1, PERF_SC, PERF_FC);

    // FLUSH_CYCLES=3 instance: back-to-back flush restarts the window.
    step("b2b_reqA",      1, 0,  0, 0, 6'd0, 1, 32'hA000,     6'h00, 0, 32'h0,        0);
    step("b2b_A1",        1, 0,  0, 0, 6'd0, 0, 32'h0,        6'h00, 1, 32'hA000,     1);
    step("b2b_reqB",      1, 0,  0, 0, 6'd0, 1, 32'hB000,     6'h00, 1, 32'hA000,     1);
    step("b2b_B1",        1, 0,  0, 0, 6'd0, 0, 32'h0,        6'h00, 1, 32'hB000,     1);
    step("b2b_B2_load",   1, 0,  1, 0, 6'd0, 0, 32'h0,        6'h00, 1, 32'hB000,     1);
    step("b2b_B3",        1, 0,  0, 0, 6'd0, 0, 32'h0,        6'h00, 1, 32'hB000,     1);
    step("b2b_drop",      1, 0,  0, 0, 6'd0, 0, 32'h0,        6'h00, 0, 32'hB000,     0);

    // Drain: every pushed expectation must have been consumed.
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
